alu_stream_driver: RTL and testbench

//  Byte-stream front end for the combinational ALU: assembles a command frame (mode, num1, num2)

---
 rtl/alu_stream_pkg.sv | 41 ++++
 rtl/alu_stream_driver_if.sv | 21 ++
 rtl/alu_byte_serializer.sv | 70 +++++++
 rtl/alu_stream_driver.sv | 149 ++++++++++++++
 tb/tb_alu_stream_driver.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_stream_pkg.sv
// Shared types and constants for the ALU byte-stream front end.
package alu_stream_pkg;

  // Frame-assembly / result-send sequencing.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

  // ALU mode_sel encodings. Anything not listed is invalid and the ALU flags it.
  localparam logic [3:0] MODE_SUB  = 4'h0;
  localparam logic [3:0] MODE_ADD  = 4'h1;
  localparam logic [3:0] MODE_AND  = 4'h2;
  localparam logic [3:0] MODE_OR   = 4'h3;
  localparam logic [3:0] MODE_XOR  = 4'h4;
  localparam logic [3:0] MODE_RMV  = 4'h5;
  localparam logic [3:0] MODE_LMV  = 4'h6;
  localparam logic [3:0] MODE_ARMV = 4'h7;
  localparam logic [3:0] MODE_TEST = 4'hF;

  // Bit positions inside the status byte (first byte of the result frame).
  localparam int STAT_EQ  = 0;
  localparam int STAT_SLT = 1;
  localparam int STAT_ULT = 2;
  localparam int STAT_ERR = 3;

  // Status byte built from the ALU's flag outputs; upper nibble always zero.
  function automatic logic [7:0] make_status(input logic err, input logic [2:0] flags);
    logic [7:0] s;
    s           = 8'h00;
    s[STAT_EQ]  = flags[0];
    s[STAT_SLT] = flags[1];
    s[STAT_ULT] = flags[2];
    s[STAT_ERR] = err;
    return s;
  endfunction

endpackage

// File: rtl/alu_stream_driver_if.sv
// Byte-stream handshake bundle: command bytes in, result bytes out.
// slave = the driver block, master = the byte source / sink.
interface alu_stream_driver_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/alu_byte_serializer.sv
// Result-frame serialiser: captures {status, ans} in one cycle and emits it
// LSB byte first under valid/ready. With ALU_STREAM_CHECKSUM_EN defined a
// trailing XOR checksum byte is appended and carries out_last.
module alu_byte_serializer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [7:0]       status_i,
  input  logic [WIDTH-1:0] ans_i,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic             out_valid_o,
  output logic             out_last_o,
  output logic             done_o
);
  localparam int NB = WIDTH / 8;
`ifdef ALU_STREAM_CHECKSUM_EN
  localparam int NBYTES = NB + 2;
`else
  localparam int NBYTES = NB + 1;
`endif
  localparam int FW = 8 * NBYTES;
  localparam int RW = $clog2(NBYTES + 1);

  logic [FW-1:0] shift_q;
  logic [RW-1:0] rem_q;
  logic [FW-1:0] frame_w;
  logic          xfer_w;

`ifdef ALU_STREAM_CHECKSUM_EN
  logic [7:0] csum_w;

  // Checksum covers the status byte and every ans byte.
  always_comb begin
    csum_w = status_i;
    for (int i = 0; i < NB; i++) begin
      csum_w = csum_w ^ ans_i[i*8 +: 8];
    end
  end

  assign frame_w = {csum_w, ans_i, status_i};
`else
  assign frame_w = {ans_i, status_i};
`endif

  assign xfer_w = out_valid_o & out_ready_i;

  // Shift register drops one byte per accepted transfer; rem_q counts what is left.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q <= '0;
      rem_q   <= '0;
    end else if (load_i) begin
      shift_q <= frame_w;
      rem_q   <= RW'(NBYTES);
    end else if (xfer_w) begin
      shift_q <= shift_q >> 8;
      rem_q   <= rem_q - RW'(1);
    end
  end

  // Outputs come straight from registers, so they hold while the sink stalls.
  assign out_data_o  = shift_q[7:0];
  assign out_valid_o = (rem_q != '0);
  assign out_last_o  = (rem_q == RW'(1));
  assign done_o      = xfer_w & out_last_o;

endmodule

// File: rtl/alu_stream_driver.sv
// Byte-stream front end for the combinational ALU: deserialises a
// (mode, num1, num2) command frame into registered ALU inputs, waits one
// cycle for the ALU to settle and streams {status, ans} back out.
// Optional build macro: ALU_STREAM_CHECKSUM_EN (adds a checksum byte to the result frame).
module alu_stream_driver
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  alu_stream_driver_if.slave   s,
  output logic [WIDTH-1:0]     alu_num1,
  output logic [WIDTH-1:0]     alu_num2,
  output logic [3:0]           alu_mode,
  input  logic [WIDTH-1:0]     alu_ans,
  input  logic [2:0]           alu_sub_flag,
  input  logic                 alu_error,
  output logic                 busy
);
  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] num1_q, num2_q;
  logic [3:0]      mode_q;
  logic            in_xfer_w;
  logic            cnt_last_w;
  logic            ser_load_w;
  logic            ser_done_w;
  logic [7:0]      ser_data_w;
  logic            ser_valid_w;
  logic            ser_last_w;

  assign s.in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
  assign in_xfer_w   = s.in_valid & s.in_ready;
  assign cnt_last_w  = (cnt_q == CW'(NB - 1));

  // Next-state and byte-counter logic; counter restarts on every state change.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ser_load_w = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_xfer_w) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
        end
      end
      ST_LOAD_A: begin
        if (in_xfer_w) begin
          if (cnt_last_w) begin
            state_d = ST_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_LOAD_B: begin
        if (in_xfer_w) begin
          if (cnt_last_w) begin
            state_d = ST_EXEC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_EXEC: begin
        ser_load_w = 1'b1;
        state_d    = ST_SEND;
        cnt_d      = '0;
      end
      ST_SEND: begin
        if (ser_done_w) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and byte-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mode byte: only the low nibble reaches the ALU; invalid codes pass through unchecked.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= '0;
    end else if (in_xfer_w && state_q == ST_IDLE) begin
      mode_q <= s.in_data[3:0];
    end
  end

  // Operand lanes: each accepted byte lands in its own lane and holds until overwritten.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    // Lane gi of each operand is written by the gi-th byte of its field.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        num1_q[gi*8 +: 8] <= '0;
        num2_q[gi*8 +: 8] <= '0;
      end else if (in_xfer_w && cnt_q == CW'(gi)) begin
        if (state_q == ST_LOAD_A) num1_q[gi*8 +: 8] <= s.in_data;
        if (state_q == ST_LOAD_B) num2_q[gi*8 +: 8] <= s.in_data;
      end
    end
  end

  assign alu_num1 = num1_q;
  assign alu_num2 = num2_q;
  assign alu_mode = mode_q;
  assign busy     = (state_q != ST_IDLE);

  // Loaded at the end of EXEC, when the ALU has seen stable operands for a full cycle.
  alu_byte_serializer #(
    .WIDTH (WIDTH)
  ) u_ser (
    .clk         (clk),
    .rstn        (rstn),
    .load_i      (ser_load_w),
    .status_i    (make_status(alu_error, alu_sub_flag)),
    .ans_i       (alu_ans),
    .out_ready_i (s.out_ready),
    .out_data_o  (ser_data_w),
    .out_valid_o (ser_valid_w),
    .out_last_o  (ser_last_w),
    .done_o      (ser_done_w)
  );

  assign s.out_data  = ser_data_w;
  assign s.out_valid = ser_valid_w;
  assign s.out_last  = ser_last_w;

endmodule

// File: tb/tb_alu_stream_driver.sv
// Self-checking bench for alu_stream_driver (WIDTH=32) with a behavioural ALU.
// Honours ALU_STREAM_CHECKSUM_EN so the same bench covers both builds.
module tb_alu_stream_driver;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] alu_num1, alu_num2, alu_ans;
  logic [3:0]  alu_mode;
  logic [2:0]  alu_sub_flag;
  logic        alu_error;
  logic        busy;
  int          total = 0;
  int          bad = 0;
  bit          gaps_en = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [7:0]  exp_q[$];

  alu_stream_driver_if bus ();

  alu_stream_driver #(.WIDTH(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s            (bus.slave),
    .alu_num1     (alu_num1),
    .alu_num2     (alu_num2),
    .alu_mode     (alu_mode),
    .alu_ans      (alu_ans),
    .alu_sub_flag (alu_sub_flag),
    .alu_error    (alu_error),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {error, ult, slt, eq, ans}.
  function automatic logic [35:0] alu_fn(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (m)
      4'h0: r = a - b;
      4'h1: r = a + b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a >> b[4:0];
      4'h6: r = a << b[4:0];
      4'h7: r = $unsigned($signed(a) >>> b[4:0]);
      4'hF: r = 32'h0;
      default: begin r = 32'h0; e = 1'b1; end
    endcase
    return {e, (a < b), ($signed(a) < $signed(b)), (a == b), r};
  endfunction

  always_comb {alu_error, alu_sub_flag, alu_ans} = alu_fn(alu_mode, alu_num1, alu_num2);

  task automatic note_fail(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    bad++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Expected result frame: status, ans LSB first, optional XOR checksum.
  task automatic build_exp(input logic [7:0] st, input logic [31:0] ans);
    logic [7:0] cs;
    exp_q.delete();
    exp_q.push_back(st);
    cs = st;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ans[i*8 +: 8]);
      cs = cs ^ ans[i*8 +: 8];
    end
`ifdef ALU_STREAM_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    total++; if (bus.in_ready !== 1'b1) note_fail({tag, "_in_ready"}, bus.in_ready, 1'b1);
    total++; if (bus.out_valid !== 1'b0) note_fail({tag, "_out_valid"}, bus.out_valid, 1'b0);
    total++; if (bus.out_last !== 1'b0) note_fail({tag, "_out_last"}, bus.out_last, 1'b0);
    total++; if (bus.out_data !== 8'h00) note_fail({tag, "_out_data"}, bus.out_data, 8'h00);
    total++; if (busy !== 1'b0) note_fail({tag, "_busy"}, busy, 1'b0);
    total++; if (alu_num1 !== 32'h0) note_fail({tag, "_num1"}, alu_num1, 32'h0);
    total++; if (alu_num2 !== 32'h0) note_fail({tag, "_num2"}, alu_num2, 32'h0);
    total++; if (alu_mode !== 4'h0) note_fail({tag, "_mode"}, alu_mode, 4'h0);
  endtask

  // Presents one byte, optionally after an idle gap; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int gap;
    int n;
    gap = gaps_en ? int'($urandom_range(0, 3)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++;
      if (bus.in_ready !== 1'b1) note_fail("in_ready_timeout", bus.in_ready, 1'b1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  // Collects the result frame; bp holds out_ready low 5 cycles on ans byte 2.
  task automatic recv_frame(input string tag, input bit bp);
    int idx;
    int cyc;
    int hold;
    logic [7:0] held;
    logic       exp_last;
    idx = 0; cyc = 0; hold = 0; held = 8'h00;
    while (idx < exp_q.size() && cyc < 2000) begin
      cyc++;
      if (bp && idx == 3 && hold < 5) begin
        bus.out_ready = 1'b0;
        if (hold == 0) begin
          held = bus.out_data;
        end else begin
          total++;
          if (bus.out_data !== held) note_fail({tag, "_stall_data"}, bus.out_data, held);
        end
        hold++;
      end else begin
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (bus.out_valid) begin
        total++;
        if (bus.in_ready !== 1'b0) note_fail({tag, "_in_ready_send"}, bus.in_ready, 1'b0);
        if (bus.out_ready) begin
          total++;
          if (bus.out_data !== exp_q[idx]) note_fail({tag, "_byte"}, bus.out_data, exp_q[idx]);
          exp_last = (idx == exp_q.size() - 1);
          total++;
          if (bus.out_last !== exp_last) note_fail({tag, "_last"}, bus.out_last, exp_last);
          idx++;
        end
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    if (cyc >= 2000) begin
      total++;
      if (idx !== exp_q.size()) note_fail({tag, "_frame_timeout"}, idx, exp_q.size());
    end
    total++; if (busy !== 1'b0) note_fail({tag, "_idle_busy"}, busy, 1'b0);
    total++; if (bus.out_valid !== 1'b0) note_fail({tag, "_idle_valid"}, bus.out_valid, 1'b0);
    total++; if (bus.in_ready !== 1'b1) note_fail({tag, "_idle_in_ready"}, bus.in_ready, 1'b1);
  endtask

  // One command frame end to end; directed frames use the given expectation.
  task automatic run_frame(input string tag, input logic [7:0] mb, input logic [31:0] a,
                           input logic [31:0] b, input bit directed,
                           input logic [7:0] e_st, input logic [31:0] e_ans, input bit bp);
    logic [35:0] r;
    if (directed) begin
      build_exp(e_st, e_ans);
    end else begin
      r = alu_fn(mb[3:0], a, b);
      build_exp({4'h0, r[35:32]}, r[31:0]);
    end
    send_byte(mb);
    for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
    for (int i = 0; i < 4; i++) send_byte(b[i*8 +: 8]);
    // Edge k accepted the last byte: EXEC now, result visible after edge k+1.
    total++; if (bus.out_valid !== 1'b0) note_fail({tag, "_exec_valid"}, bus.out_valid, 1'b0);
    total++; if (bus.in_ready !== 1'b0) note_fail({tag, "_exec_in_ready"}, bus.in_ready, 1'b0);
    total++; if (busy !== 1'b1) note_fail({tag, "_exec_busy"}, busy, 1'b1);
    total++; if (alu_mode !== mb[3:0]) note_fail({tag, "_mode_out"}, alu_mode, mb[3:0]);
    total++; if (alu_num1 !== a) note_fail({tag, "_num1_out"}, alu_num1, a);
    total++; if (alu_num2 !== b) note_fail({tag, "_num2_out"}, alu_num2, b);
    @(posedge clk); #1;
    total++; if (bus.out_valid !== 1'b1) note_fail({tag, "_lat_valid"}, bus.out_valid, 1'b1);
    recv_frame(tag, bp);
    $display("frame %s mode=%02h a=%08h b=%08h status=%02h total=%0d bad=%0d",
             tag, mb, a, b, exp_q[0], total, bad);
  endtask

  initial begin
    logic [7:0]  mb;
    logic [31:0] ra, rb;
    logic [3:0]  modes [10];
    modes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hF};
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check_reset_vals("por");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    run_frame("add",   8'h01, 32'h5, 32'h3, 1'b1, 8'h00, 32'h0000_0008, 1'b0);
    run_frame("sub",   8'h00, 32'h3, 32'h5, 1'b1, 8'h06, 32'hFFFF_FFFE, 1'b0);
    run_frame("armv",  8'h07, 32'h8000_0000, 32'h4, 1'b1, 8'h02, 32'hF800_0000, 1'b0);
    run_frame("f1add", 8'hF1, 32'h5, 32'h3, 1'b1, 8'h00, 32'h0000_0008, 1'b0);
    run_frame("inval", 8'h08, 32'hA, 32'hA, 1'b1, 8'h09, 32'h0000_0000, 1'b0);
    run_frame("bp",    8'h01, 32'h1234_5678, 32'h1111_1111, 1'b1, 8'h00, 32'h2345_6789, 1'b1);

    // Abort after three input bytes.
    send_byte(8'h01);
    send_byte(8'h05);
    send_byte(8'h00);
    total++; if (busy !== 1'b1) note_fail("partial_busy", busy, 1'b1);
    rstn = 1'b0;
    #2;
    check_reset_vals("abort");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_frame("add_after_rst", 8'h01, 32'h5, 32'h3, 1'b1, 8'h00, 32'h0000_0008, 1'b0);

    // Randomised frames with input gaps and output backpressure.
    gaps_en  = 1'b1;
    rand_rdy = 1'b1;
    for (int t = 0; t < 24; t++) begin
      mb = {4'($urandom_range(0, 15)), modes[$urandom_range(0, 9)]};
      ra = $urandom;
      rb = (t % 3 == 0) ? ra : $urandom;
      run_frame("rand", mb, ra, rb, 1'b0, 8'h00, 32'h0, (t % 4 == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
